stream_packer: RTL and testbench

STREAM_PACKER -- requirements
Module: stream_packer

---
 rtl/stream_pkg.sv | 18 +
 rtl/stream_packer.sv | 129 ++++++++++++
 tb/tb_stream_packer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared types and default sizing for the stream packer
//
// Contents:
//   state_t      : packer FSM state (ACCUM: output register empty, FULL: holds unsent word)
//   DEF_SIZEDATA : default width of one input word in bits
//   DEF_RATIO    : default number of input words packed into one output word

package stream_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int DEF_SIZEDATA = 32;
    localparam int DEF_RATIO    = 4;

endpackage

// File: rtl/stream_packer.sv
// rtl/stream_packer.sv - packs RATIO narrow stream words into one wide word
//
// Optional feature macro: STREAM_PACKER_LAST_EN (adds last_i, last_o, keep_o)
//
// Parameters:
//   SIZEDATA : width of one input word
//   RATIO    : input words per output word (2..16)
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous active-high reset
//   valid_i  : upstream word valid (fifo read side)
//   data_i   : upstream word
//   ready_o  : block accepts data_i this cycle
//   valid_o  : packed word valid (registered)
//   data_o   : packed word, lane k at [k*SIZEDATA +: SIZEDATA], first beat in lane 0
//   ready_i  : downstream accepts data_o
//   last_i   : (LAST_EN) closes the current word early
//   last_o   : (LAST_EN) word was closed by last_i
//   keep_o   : (LAST_EN) one bit per lane, set for lanes that carry data

module stream_packer
    import stream_pkg::*;
#(
    parameter int SIZEDATA = DEF_SIZEDATA,
    parameter int RATIO    = DEF_RATIO
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      valid_i,
    input  logic [SIZEDATA-1:0]       data_i,
    output logic                      ready_o,
    output logic                      valid_o,
    output logic [SIZEDATA*RATIO-1:0] data_o,
    input  logic                      ready_i
`ifdef STREAM_PACKER_LAST_EN
    ,
    input  logic                      last_i,
    output logic                      last_o,
    output logic [RATIO-1:0]          keep_o
`endif
);

    localparam int BITSCONT = $clog2(RATIO);
    localparam int WIDTH    = SIZEDATA * RATIO;
    localparam logic [BITSCONT-1:0] LAST_IDX = BITSCONT'(RATIO - 1);

    state_t              state;
    logic [BITSCONT-1:0] idx;
    logic [WIDTH-1:0]    acc;
    logic [WIDTH-1:0]    acc_next;
    logic [WIDTH-1:0]    out_reg;
    logic                valid_q;
    logic                in_fire;
    logic                word_done;

    // In FULL a new beat may only enter while the pending word leaves,
    // which gives back-to-back words without a bubble.
    assign ready_o = (state == ACCUM) ? 1'b1 : ready_i;
    assign in_fire = valid_i && ready_o;
    assign valid_o = valid_q;
    assign data_o  = out_reg;

    // Accumulator with the current beat merged into lane idx; this is
    // what gets copied to the output register when the word completes.
    always_comb begin
        acc_next = acc;
        for (int k = 0; k < RATIO; k++) begin
            if (idx == BITSCONT'(k)) begin
                acc_next[k*SIZEDATA +: SIZEDATA] = data_i;
            end
        end
    end

`ifdef STREAM_PACKER_LAST_EN
    logic [RATIO-1:0] keep_next;
    logic [RATIO-1:0] keep_q;
    logic             last_q;

    // Lanes 0..idx have been written once the current beat lands.
    always_comb begin
        keep_next = '0;
        for (int k = 0; k < RATIO; k++) begin
            keep_next[k] = (BITSCONT'(k) <= idx);
        end
    end

    assign word_done = in_fire && (last_i || (idx == LAST_IDX));
    assign keep_o    = keep_q;
    assign last_o    = last_q;
`else
    assign word_done = in_fire && (idx == LAST_IDX);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ACCUM;
            idx     <= '0;
            acc     <= '0;
            out_reg <= '0;
            valid_q <= 1'b0;
`ifdef STREAM_PACKER_LAST_EN
            keep_q  <= '0;
            last_q  <= 1'b0;
`endif
        end else if (word_done) begin
            // Either state: load the finished word; in FULL this only
            // happens while the previous word is being taken.
            out_reg <= acc_next;
            acc     <= '0;
            idx     <= '0;
            state   <= FULL;
            valid_q <= 1'b1;
`ifdef STREAM_PACKER_LAST_EN
            keep_q  <= keep_next;
            last_q  <= last_i;
`endif
        end else begin
            if (in_fire) begin
                acc <= acc_next;
                idx <= idx + BITSCONT'(1);
            end
            if (valid_q && ready_i) begin
                state   <= ACCUM;
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_packer.sv
// tb/tb_stream_packer.sv - directed self-checking bench for stream_packer

module tb_stream_packer;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         valid_i;
    logic [31:0]  data_i;
    logic         ready_o;
    logic         valid_o;
    logic [127:0] data_o;
    logic         ready_i;
    logic         last_i;
`ifdef STREAM_PACKER_LAST_EN
    logic         last_o;
    logic [3:0]   keep_o;
`endif

    int checks = 0;
    int errors = 0;
    logic [127:0] cap_q[$];
    logic [127:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    stream_packer #(.SIZEDATA(32), .RATIO(4)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .ready_i (ready_i)
`ifdef STREAM_PACKER_LAST_EN
        ,
        .last_i  (last_i),
        .last_o  (last_o),
        .keep_o  (keep_o)
`endif
    );

    // Inputs change at posedge+1, so at negedge a visible handshake is
    // exactly the transfer that the next rising edge performs.
    always @(negedge clk_i) begin
        if (!rst_i && valid_o && ready_i) cap_q.push_back(data_o);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one beat and hold it until accepted; returns the number of
    // cycles ready_o was low. Leaves valid_i high for back-to-back use.
    task automatic beat(input logic [31:0] d, input logic l, output int stalls);
        valid_i = 1'b1;
        data_i  = d;
        last_i  = l;
        stalls  = 0;
        @(negedge clk_i);
        while (!ready_o && stalls < 50) begin
            stalls++;
            @(negedge clk_i);
        end
        if (!ready_o) check("beat_accept_timeout", ready_o, 1'b1);
        @(posedge clk_i);
        #1;
        last_i = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic compare_queue(input string tag);
        check({tag, "_count"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            check($sformatf("%s_word%0d", tag, i), cap_q[i], exp_q[i]);
        cap_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int st;
        int total;
        logic [127:0] w;
        logic [31:0] r;

        rst_i   = 1'b1;
        valid_i = 1'b0;
        data_i  = '0;
        ready_i = 1'b1;
        last_i  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk_i);
        check("rst_valid_o", valid_o, 1'b0);
        check("rst_data_o", data_o, 128'h0);
        check("rst_ready_o", ready_o, 1'b1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Basic 4-beat word, 1-cycle latency
        beat(32'h1, 1'b0, st);
        beat(32'h2, 1'b0, st);
        beat(32'h3, 1'b0, st);
        check("t1_valid_before_4th", valid_o, 1'b0);
        beat(32'h4, 1'b0, st);
        check("t1_valid_after_4th", valid_o, 1'b1);
        check("t1_data_o", data_o, 128'h00000004_00000003_00000002_00000001);
        idle(1);
        check("t1_valid_dropped", valid_o, 1'b0);
        exp_q.push_back(128'h00000004_00000003_00000002_00000001);
        idle(2);
        compare_queue("t1");

        // 12 back-to-back random beats
        total = 0;
        w = '0;
        for (int i = 0; i < 12; i++) begin
            r = $urandom;
            w[(i%4)*32 +: 32] = r;
            if (i % 4 == 3) begin
                exp_q.push_back(w);
                w = '0;
            end
            beat(r, 1'b0, st);
            total += st;
        end
        check("t2_ready_o_stalls", total, 0);
        idle(3);
        compare_queue("t2");

        // Backpressure: word held stable, then zero-bubble hand-off
        ready_i = 1'b0;
        beat(32'h11, 1'b0, st);
        beat(32'h22, 1'b0, st);
        beat(32'h33, 1'b0, st);
        beat(32'h44, 1'b0, st);
        data_i = 32'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check($sformatf("t3_hold_valid_%0d", i), valid_o, 1'b1);
            check($sformatf("t3_hold_data_%0d", i), data_o, 128'h00000044_00000033_00000022_00000011);
            check($sformatf("t3_hold_ready_%0d", i), ready_o, 1'b0);
        end
        @(posedge clk_i);
        #1;
        ready_i = 1'b1;
        beat(32'h55, 1'b0, st);
        check("t3_same_cycle_accept_stalls", st, 0);
        check("t3_valid_after_handoff", valid_o, 1'b0);
        beat(32'h66, 1'b0, st);
        beat(32'h77, 1'b0, st);
        beat(32'h88, 1'b0, st);
        check("t3_second_word", data_o, 128'h00000088_00000077_00000066_00000055);
        idle(3);
        exp_q.push_back(128'h00000044_00000033_00000022_00000011);
        exp_q.push_back(128'h00000088_00000077_00000066_00000055);
        compare_queue("t3");

        // Reset mid-word discards the partial word
        beat(32'hA, 1'b0, st);
        beat(32'hB, 1'b0, st);
        valid_i = 1'b0;
        rst_i = 1'b1;
        #1;
        check("t4_rst_valid_o", valid_o, 1'b0);
        check("t4_rst_data_o", data_o, 128'h0);
        check("t4_rst_ready_o", ready_o, 1'b1);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        beat(32'h1, 1'b0, st);
        beat(32'h2, 1'b0, st);
        beat(32'h3, 1'b0, st);
        beat(32'h4, 1'b0, st);
        idle(3);
        exp_q.push_back(128'h00000004_00000003_00000002_00000001);
        compare_queue("t4");

`ifdef STREAM_PACKER_LAST_EN
        // Early close with last_i
        beat(32'hA, 1'b0, st);
        beat(32'hB, 1'b1, st);
        check("t5_valid_o", valid_o, 1'b1);
        check("t5_data_o", data_o, 128'h0000000B_0000000A);
        check("t5_keep_o", keep_o, 4'b0011);
        check("t5_last_o", last_o, 1'b1);
        idle(2);
        beat(32'h1, 1'b0, st);
        beat(32'h2, 1'b0, st);
        beat(32'h3, 1'b0, st);
        beat(32'h4, 1'b0, st);
        check("t5_full_keep_o", keep_o, 4'b1111);
        check("t5_full_last_o", last_o, 1'b0);
        idle(3);
        exp_q.push_back(128'h0000000B_0000000A);
        exp_q.push_back(128'h00000004_00000003_00000002_00000001);
        compare_queue("t5");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
